note_track_engine: RTL

//  Per-lane note scheduler. Holds up to SLOTS falling notes and advances each by STEP rows per frame.

---
 rtl/beat_pkg.sv | 31 +++
 rtl/note_slot.sv | 64 ++++++
 rtl/note_track_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// Shared constants and types for the rhythm-game lane logic.
// Every lane instance and the score block agree on row geometry through
// this package.
package beat_pkg;

    // Playfield geometry, in rows.
    localparam int Y_MAX_ROW  = 400;  // last legal row; leaving it is a miss
    localparam int NOTE_STEP  = 5;    // rows advanced per video frame
    localparam int HIT_WIN_LO = 360;  // first row of the hit window (inclusive)
    localparam int HIT_WIN_HI = 400;  // last row of the hit window (inclusive)
    localparam int NUM_LANES  = 5;    // lanes on the playfield, one engine each

    localparam int ROW_W      = 10;   // bits per row value
    localparam int COUNT_W    = 16;   // bits per hit/miss counter

    // Row position of a note; Y_MAX_ROW + NOTE_STEP still fits without wrap.
    typedef logic [ROW_W-1:0]   row_t;

    // Hit/miss tally as seen by the score block.
    typedef logic [COUNT_W-1:0] count_t;

    // Add a small increment to a counter, clamping at all-ones instead of
    // wrapping. The increment is wide enough for every slot expiring at once
    // plus an empty strike.
    function automatic count_t sat_add(input count_t base, input logic [4:0] inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, base} + {{(COUNT_W-4){1'b0}}, inc};
        return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/note_slot.sv
// One note slot of a lane: an active flag plus the note's current row.
// free wins over alloc and tick, so a struck note is neither advanced nor
// counted as expired. A note sitting on the last row expires on the next tick.
module note_slot
    import beat_pkg::*;
#(
    parameter int STEP  = NOTE_STEP,
    parameter int Y_MAX = Y_MAX_ROW
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick_i,     // frame advance
    input  logic alloc_i,    // start a new note at row 0 (only driven for a free slot)
    input  logic free_i,     // note was struck (only driven for an active slot)
    output logic active_o,
    output row_t y_o,
    output logic expire_o    // note leaves the last row during this cycle
);

    logic active_q, active_d;
    row_t y_q, y_d;

    // Next-state: free, then alloc, then frame advance / expiry.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        active_d = active_q;
        y_d      = y_q;
        expire_o = 1'b0;

        if (free_i) begin
            active_d = 1'b0;
            y_d      = '0;
        end else if (alloc_i) begin
            active_d = 1'b1;
            y_d      = '0;
        end else if (tick_i && active_q) begin
            if (y_q == row_t'(Y_MAX)) begin
                active_d = 1'b0;
                y_d      = '0;
                expire_o = 1'b1;
            end else begin
                y_d = y_q + row_t'(STEP);
            end
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (Reset) begin
            active_q <= 1'b0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign y_o      = y_q;

endmodule

// File: rtl/note_track_engine.sv
// Per-lane note scheduler. Holds up to SLOTS falling notes, advances them
// once per video frame, judges key strikes against the hit window and
// reports hit/miss events and saturating tallies to the score block.
module note_track_engine
    import beat_pkg::*;
#(
    parameter int SLOTS  = 8,
    parameter int STEP   = NOTE_STEP,
    parameter int Y_MAX  = Y_MAX_ROW,
    parameter int HIT_LO = HIT_WIN_LO,
    parameter int HIT_HI = HIT_WIN_HI
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic                  spawn,
    output logic                  spawn_ready,
    input  logic                  key_press,
    output logic [SLOTS-1:0]      slot_active,
    output logic [SLOTS*ROW_W-1:0] slot_y,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic [COUNT_W-1:0]    hit_count,
    output logic [COUNT_W-1:0]    miss_count
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    // ------------------------------------------------------------------
    // Key edge detect: a strike is the first high cycle after a low one.
    // ------------------------------------------------------------------
    logic key_q, key_d;
    logic strike;

    assign key_d  = key_press;
    assign strike = key_press & ~key_q;

    // ------------------------------------------------------------------
    // Slot array
    // ------------------------------------------------------------------
    row_t             y_arr [SLOTS];
    logic [SLOTS-1:0] expire_vec;
    logic [SLOTS-1:0] alloc_vec;
    logic [SLOTS-1:0] free_vec;
    logic [SLOTS-1:0] in_win;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        note_slot #(
            .STEP  (STEP),
            .Y_MAX (Y_MAX)
        ) u_slot (
            .Clk      (Clk),
            .Reset    (Reset),
            .tick_i   (frame_tick),
            .alloc_i  (alloc_vec[i]),
            .free_i   (free_vec[i]),
            .active_o (slot_active[i]),
            .y_o      (y_arr[i]),
            .expire_o (expire_vec[i])
        );

        assign slot_y[ROW_W*i +: ROW_W] = y_arr[i];

        // Window test uses the pre-tick row, so a strike and a tick in the
        // same cycle still judge the note where the player saw it.
        assign in_win[i] = slot_active[i]
                         && (y_arr[i] >= row_t'(HIT_LO))
                         && (y_arr[i] <= row_t'(HIT_HI));
    end

    // ------------------------------------------------------------------
    // Strike target: in-window note with the largest row, lowest index on ties.
    // ------------------------------------------------------------------
    logic             target_found;
    logic [IDX_W-1:0] target_idx;
    row_t             target_y;

    // Priority select over the window hits; strict '>' keeps the lowest index on ties.
    always_comb begin
        target_found = 1'b0;
        target_idx   = '0;
        target_y     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (in_win[i] && (!target_found || (y_arr[i] > target_y))) begin
                target_found = 1'b1;
                target_idx   = IDX_W'(i);
                target_y     = y_arr[i];
            end
        end
    end

    // Free the struck slot; freeing takes priority over that slot's tick.
    always_comb begin
        free_vec = '0;
        if (strike && target_found) begin
            free_vec[target_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Spawn allocation: lowest-index slot that is free *before* this edge,
    // so a slot freed this cycle only becomes reusable next cycle.
    // ------------------------------------------------------------------
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    assign spawn_ready = ~&slot_active;

    // Lowest-index free slot encoder.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!slot_active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // One-hot allocation; a spawn with no free slot is dropped.
    always_comb begin
        alloc_vec = '0;
        if (spawn && free_found) begin
            alloc_vec[free_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event pulses and saturating tallies
    // ------------------------------------------------------------------
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    count_t      hit_count_q, hit_count_d;
    count_t      miss_count_q, miss_count_d;
    logic [4:0]  miss_inc;

    // Count expired slots plus an empty strike; pulse once however many there are.
    always_comb begin
        miss_inc = '0;
        for (int i = 0; i < SLOTS; i++) begin
            miss_inc = miss_inc + 5'(expire_vec[i]);
        end
        if (strike && !target_found) begin
            miss_inc = miss_inc + 5'd1;
        end

        hit_pulse_d  = strike & target_found;
        miss_pulse_d = (miss_inc != 5'd0);
        hit_count_d  = hit_pulse_d ? sat_add(hit_count_q, 5'd1) : hit_count_q;
        miss_count_d = sat_add(miss_count_q, miss_inc);
    end

    // Event, counter and key-edge registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q        <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            key_q        <= key_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule
